code_sequencer: RTL and testbench

CODE_SEQUENCER -- requirements
Module: code_sequencer

---
 rtl/code_sequencer.sv | 151 +++++++++++++++
 tb/tb_code_sequencer.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/code_sequencer.sv
// rtl/code_sequencer.sv - periodic chip-code burst sequencer (IDLE/RUN/WAIT)
module code_sequencer #(
    parameter int NB_CODE   = 32,
    parameter int NB_CHIP   = 16,
    parameter int NB_PERIOD = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic [NB_CODE-1:0]   code_word,
    input  logic [5:0]           code_len,
    input  logic [NB_CHIP-1:0]   chip_len,
    input  logic [NB_PERIOD-1:0] period,
    output logic                 code,
    output logic                 sinc,
    output logic                 burst_start,
    output logic                 busy,
    output logic                 cfg_err
);

    typedef enum logic [1:0] {IDLE, RUN, WAIT} state_t;

    localparam logic [6:0] MAX_LEN = 7'(NB_CODE);

    state_t               state, state_n;
    logic [1:0]           rst_sync;
    logic [NB_CODE-1:0]   shreg, shreg_n;
    logic [5:0]           len_l, len_n;
    logic [NB_CHIP-1:0]   chip_l, chip_n;
    logic [NB_PERIOD-1:0] per_l, per_n;
    logic [5:0]           idx, idx_n;
    logic [NB_CHIP-1:0]   chip_cnt, chip_cnt_n;
    logic [NB_PERIOD-1:0] per_cnt, per_cnt_n, per_inc;
    logic                 code_n, sinc_n, burst_start_n, busy_n, cfg_err_n;
    logic                 try_start, start_ok;

    // Reset asserts asynchronously but releases the FSM only after two clock edges.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) rst_sync <= 2'b00;
        else      rst_sync <= {rst_sync[0], 1'b1};
    end

    assign start_ok = (code_len != 6'd0) && ({1'b0, code_len} <= MAX_LEN);
    assign per_inc  = (per_cnt == '1) ? per_cnt : per_cnt + NB_PERIOD'(1);

    always_comb begin
        state_n       = state;
        shreg_n       = shreg;
        len_n         = len_l;
        chip_n        = chip_l;
        per_n         = per_l;
        idx_n         = idx;
        chip_cnt_n    = chip_cnt;
        per_cnt_n     = per_cnt;
        code_n        = 1'b0;
        sinc_n        = 1'b0;
        burst_start_n = 1'b0;
        cfg_err_n     = 1'b0;
        try_start     = 1'b0;
        case (state)
            IDLE: try_start = enable;
            RUN: begin
                per_cnt_n = per_inc;
                sinc_n    = 1'b1;
                code_n    = code;
                if (chip_cnt == chip_l - NB_CHIP'(1)) begin
                    if (idx == len_l - 6'd1) begin
                        sinc_n = 1'b0;
                        code_n = 1'b0;
                        // A period shorter than the burst is already spent: restart or stop now.
                        if (per_cnt >= per_l) begin
                            if (enable) try_start = 1'b1;
                            else        state_n   = IDLE;
                        end else begin
                            state_n = WAIT;
                        end
                    end else begin
                        idx_n      = idx + 6'd1;
                        chip_cnt_n = '0;
                        shreg_n    = shreg >> 1;
                        code_n     = shreg[1];
                    end
                end else begin
                    chip_cnt_n = chip_cnt + NB_CHIP'(1);
                end
            end
            WAIT: begin
                per_cnt_n = per_inc;
                if (per_cnt >= per_l) begin
                    if (enable) try_start = 1'b1;
                    else        state_n   = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
        if (try_start) begin
            if (start_ok) begin
                state_n       = RUN;
                shreg_n       = code_word;
                len_n         = code_len;
                chip_n        = (chip_len == '0) ? NB_CHIP'(1) : chip_len;
                per_n         = period;
                idx_n         = '0;
                chip_cnt_n    = '0;
                per_cnt_n     = NB_PERIOD'(1);
                code_n        = code_word[0];
                sinc_n        = 1'b1;
                burst_start_n = 1'b1;
            end else begin
                state_n   = IDLE;
                code_n    = 1'b0;
                sinc_n    = 1'b0;
                cfg_err_n = 1'b1;
            end
        end
        busy_n = (state_n != IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst || !rst_sync[1]) begin
            state       <= IDLE;
            shreg       <= '0;
            len_l       <= '0;
            chip_l      <= '0;
            per_l       <= '0;
            idx         <= '0;
            chip_cnt    <= '0;
            per_cnt     <= '0;
            code        <= 1'b0;
            sinc        <= 1'b0;
            burst_start <= 1'b0;
            busy        <= 1'b0;
            cfg_err     <= 1'b0;
        end else begin
            state       <= state_n;
            shreg       <= shreg_n;
            len_l       <= len_n;
            chip_l      <= chip_n;
            per_l       <= per_n;
            idx         <= idx_n;
            chip_cnt    <= chip_cnt_n;
            per_cnt     <= per_cnt_n;
            code        <= code_n;
            sinc        <= sinc_n;
            burst_start <= burst_start_n;
            busy        <= busy_n;
            cfg_err     <= cfg_err_n;
        end
    end

endmodule

// File: tb/tb_code_sequencer.sv
// tb/tb_code_sequencer.sv - self-checking bench for code_sequencer
module tb_code_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic [31:0] code_word = '0;
    logic [5:0]  code_len = '0;
    logic [15:0] chip_len = '0;
    logic [31:0] period = '0;
    logic        code, sinc, burst_start, busy, cfg_err;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic        en;
        logic [31:0] cw;
        logic [5:0]  cl;
        logic [15:0] chl;
        logic [31:0] per;
        logic [4:0]  exp;   // {code, sinc, burst_start, busy, cfg_err}
    } vec_t;

    vec_t vecs[$];

    code_sequencer dut (
        .clk(clk), .rst(rst), .enable(enable), .code_word(code_word),
        .code_len(code_len), .chip_len(chip_len), .period(period),
        .code(code), .sinc(sinc), .burst_start(burst_start),
        .busy(busy), .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [4:0] exp);
        logic [4:0] act;
        act = {code, sinc, burst_start, busy, cfg_err};
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b (code,sinc,burst_start,busy,cfg_err)", name, act, exp);
        end
    endtask

    // Called at a negedge; asserts reset mid-low-phase and checks outputs clear before the next edge.
    task automatic pulse_reset(input string name);
        #2;
        rst = 1'b0;
        enable = 1'b0;
        #1;
        check(name, 5'b00000);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic add(input logic en, input logic [31:0] cw, input logic [5:0] cl,
                       input logic [15:0] chl, input logic [31:0] per, input logic [4:0] exp);
        vecs.push_back('{en, cw, cl, chl, per, exp});
    endtask

    // Independent burst model: effective period is max(period, burst length).
    task automatic run_model(input string name, input logic [31:0] cw, input logic [31:0] cw2,
                             input int cl, input int chl, input int per, input int n,
                             input int drop_t, input int chg_t);
        int chl_e, blen, p, b, ph;
        logic alive, s_e, c_e, bs_e, busy_e;
        logic [31:0] cwx;
        chl_e = (chl == 0) ? 1 : chl;
        blen  = cl * chl_e;
        p     = (per > blen) ? per : blen;
        code_word = cw;
        code_len  = 6'(cl);
        chip_len  = 16'(chl);
        period    = 32'(per);
        enable    = 1'b1;
        for (int t = 0; t < n; t++) begin
            @(negedge clk);
            b      = t / p;
            ph     = t % p;
            alive  = (drop_t < 0) || (b == 0);
            cwx    = (chg_t >= 0 && b > 0) ? cw2 : cw;
            s_e    = alive && (ph < blen);
            c_e    = s_e ? cwx[ph / chl_e] : 1'b0;
            bs_e   = alive && (ph == 0);
            busy_e = (drop_t < 0) ? 1'b1 : (t < p);
            check($sformatf("%s t=%0d", name, t), {c_e, s_e, bs_e, busy_e, 1'b0});
            if (t == drop_t) enable = 1'b0;
            if (t == chg_t)  code_word = cw2;
        end
    endtask

    initial begin
        // chip_len=0 -> 1-clock chips; enable dropped for second burst; then refused starts
        for (int r = 0; r <= 10; r++) begin
            case (r)
                0, 10:   add(1'b1, 32'h5, 6'd3, 16'd0, 32'd10, 5'b11110);
                1:       add(1'b1, 32'h5, 6'd3, 16'd0, 32'd10, 5'b01010);
                2:       add(1'b1, 32'h5, 6'd3, 16'd0, 32'd10, 5'b11010);
                default: add(1'b1, 32'h5, 6'd3, 16'd0, 32'd10, 5'b00010);
            endcase
        end
        add(1'b0, 32'h5, 6'd3, 16'd0, 32'd10, 5'b01010);
        add(1'b0, 32'h5, 6'd3, 16'd0, 32'd10, 5'b11010);
        for (int r = 13; r <= 19; r++) add(1'b0, 32'h5, 6'd3, 16'd0, 32'd10, 5'b00010);
        add(1'b0, 32'h5, 6'd3, 16'd0, 32'd10, 5'b00000);
        add(1'b0, 32'h5, 6'd3, 16'd0, 32'd10, 5'b00000);
        for (int r = 0; r < 3; r++) add(1'b1, 32'h5, 6'd0, 16'd1, 32'd10, 5'b00001);
        add(1'b1, 32'h5, 6'd33, 16'd1, 32'd10, 5'b00001);
        add(1'b0, 32'h5, 6'd3, 16'd1, 32'd10, 5'b00000);

        @(negedge clk);
        pulse_reset("reset_state");

        for (int i = 0; i < vecs.size(); i++) begin
            enable    = vecs[i].en;
            code_word = vecs[i].cw;
            code_len  = vecs[i].cl;
            chip_len  = vecs[i].chl;
            period    = vecs[i].per;
            @(negedge clk);
            check($sformatf("vec%0d", i), vecs[i].exp);
        end

        // Barker-13 with code_word changed during chip 5 of the first burst
        pulse_reset("reset_pre_barker");
        run_model("barker", 32'h1F35, 32'h0ACB, 13, 4, 100, 230, -1, 21);
        // now in chip 7 of the third burst: async reset must clear outputs at once
        pulse_reset("reset_mid_burst");
        enable = 1'b1;
        @(negedge clk);
        check("restart_first_chip", 5'b11110);
        @(negedge clk);
        check("restart_second_cycle", 5'b11010);

        pulse_reset("reset_pre_drop");
        run_model("enable_drop", 32'h1F35, 32'h0, 13, 2, 40, 50, 4, -1);

        pulse_reset("reset_pre_short");
        run_model("short_period", 32'h3, 32'h0, 3, 2, 4, 18, -1, -1);
        pulse_reset("reset_pre_zero");
        run_model("zero_period", 32'h16, 32'h0, 5, 1, 0, 15, -1, -1);
        pulse_reset("reset_pre_full");
        run_model("full_len", 32'hDEADBEEF, 32'h0, 32, 1, 0, 70, -1, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
